wb_retire_queue: RTL and testbench

Parametrised writeback/retire stage for the five-stage pipeline, replacing the single-register MEM→WB latch with a DEPTH-entry in-order retire queue. It accepts MEM results via valid/ready instead of the global stall bus, and commits one entry per cycle to the register file when the RF/trace side is ready. It adds byte-granular write enables and a forwarding lookup over all queued, uncommitted writes for ID. It sits between the MEM stage and regfile/ID, and drives the debug trace ports.

---
 rtl/wb_retire_queue_pkg.sv | 14 +
 rtl/wb_fwd_match.sv | 27 ++
 rtl/wb_retire_queue.sv | 93 +++++++++
 tb/tb_wb_retire_queue.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/wb_retire_queue_pkg.sv
// wb_retire_queue_pkg: shared widths, retire-entry type and constants for the retire queue.
package wb_retire_queue_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_PC_W = 32;
  localparam int DEF_BE_W = DEF_DATA_W / 8;
  localparam logic [DEF_BE_W-1:0] BE_NONE = '0;
  typedef struct packed {
    logic [DEF_PC_W-1:0] pc;
    logic [DEF_BE_W-1:0] be;
    logic [DEF_ADDR_W-1:0] waddr;
    logic [DEF_DATA_W-1:0] wdata;
  } retire_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: youngest-first priority match of a lookup address over queued entries.
module wb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 5,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  cand_i,
  input  logic [ADDR_W-1:0] addr_i [DEPTH],
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [PW-1:0]     youngest_i,
  output logic              hit_o,
  output logic [PW-1:0]     sel_o
);
  logic [PW-1:0] idx;
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = youngest_i - PW'(k);
      if (!hit_o && cand_i[idx] && addr_i[idx] == raddr_i) begin
        hit_o = 1'b1;
        sel_o = idx;
      end
    end
  end
endmodule

// File: rtl/wb_retire_queue.sv
// wb_retire_queue: in-order DEPTH-entry writeback/retire queue with byte enables,
// youngest-first forwarding to ID and debug trace outputs.
module wb_retire_queue
  import wb_retire_queue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PC_W = DEF_PC_W,
  parameter int DEPTH = 4,
  localparam int BE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [BE_W-1:0]   in_be,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              rf_ready,
  output logic [BE_W-1:0]   rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] fwd_raddr,
  output logic              fwd_hit,
  output logic [BE_W-1:0]   fwd_be,
  output logic [DATA_W-1:0] fwd_data,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [BE_W-1:0]   debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [PC_W-1:0] pc_q [DEPTH];
  logic [BE_W-1:0] be_q [DEPTH];
  logic [ADDR_W-1:0] wa_q [DEPTH];
  logic [DATA_W-1:0] wd_q [DEPTH];
  logic push, pop;
  logic [DEPTH-1:0] cand;
  logic [PW-1:0] off [DEPTH];
  logic [PW-1:0] sel;
  assign in_ready = cnt_q != (PW+1)'(DEPTH);
  assign push = in_valid && in_ready;
  assign pop = (cnt_q != '0) && rf_ready;
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // r0 writes keep their slot so they still retire for trace, but never write.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_q] <= in_pc;
      be_q[wr_q] <= (in_waddr == '0) ? BE_W'(BE_NONE) : in_be;
      wa_q[wr_q] <= in_waddr;
      wd_q[wr_q] <= in_wdata;
    end
  end
  assign rf_we = pop ? be_q[rd_q] : '0;
  assign rf_waddr = wa_q[rd_q];
  assign rf_wdata = wd_q[rd_q];
  assign debug_wb_pc = pop ? pc_q[rd_q] : '0;
  assign debug_wb_rf_wen = rf_we;
  assign debug_wb_rf_wnum = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cand
    assign off[i] = PW'(i) - rd_q;
    assign cand[i] = ({1'b0, off[i]} < cnt_q) && (be_q[i] != '0) && (fwd_raddr != '0);
  end
  wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fwd (
    .cand_i(cand),
    .addr_i(wa_q),
    .raddr_i(fwd_raddr),
    .youngest_i(wr_q - 1'b1),
    .hit_o(fwd_hit),
    .sel_o(sel)
  );
  assign fwd_be = fwd_hit ? be_q[sel] : '0;
  assign fwd_data = fwd_hit ? wd_q[sel] : '0;
endmodule

// File: tb/tb_wb_retire_queue.sv
// tb_wb_retire_queue: scoreboard bench; a reference queue model predicts commits,
// in_ready and forwarding every cycle, plus directed checks around reset.
module tb_wb_retire_queue;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] pc;
    logic [3:0] be;
    logic [4:0] wa;
    logic [31:0] wd;
  } ent_t;
  logic clk = 0, resetn = 0;
  logic in_valid = 0, in_ready, rf_ready = 0, fwd_hit;
  logic [31:0] in_pc = 0, in_wdata = 0, rf_wdata, fwd_data, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0] in_be = 0, rf_we, fwd_be, debug_wb_rf_wen;
  logic [4:0] in_waddr = 0, rf_waddr, fwd_raddr = 0, debug_wb_rf_wnum;
  int checks = 0, errors = 0, mcnt = 0, commits = 0;
  ent_t q[$];

  wb_retire_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_be(in_be), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_be(fwd_be), .fwd_data(fwd_data),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: evaluated mid-cycle, then advanced as if the next edge occurred.
  always @(negedge clk) begin
    if (!resetn) begin
      q.delete();
      mcnt = 0;
    end else begin : model
      logic hit;
      ent_t e, f;
      hit = 0;
      f = '{0, 0, 0, 0};
      for (int k = q.size() - 1; k >= 0; k--)
        if (!hit && fwd_raddr != 0 && q[k].wa == fwd_raddr && q[k].be != 0) begin
          hit = 1;
          f = q[k];
        end
      check("fwd_hit", fwd_hit, hit);
      if (hit) begin
        check("fwd_be", fwd_be, f.be);
        check("fwd_data", fwd_data, f.wd);
      end
      check("in_ready", in_ready, mcnt != DEPTH);
      check("trace_wen", debug_wb_rf_wen, rf_we);
      if (mcnt != 0 && rf_ready) begin
        e = q.pop_front();
        commits++;
        check("commit_pc", debug_wb_pc, e.pc);
        check("commit_we", rf_we, e.be);
        check("commit_waddr", rf_waddr, e.wa);
        if (e.be != 0) check("commit_wdata", rf_wdata, e.wd);
      end else begin
        check("idle_we", rf_we, 0);
        check("idle_pc", debug_wb_pc, 0);
      end
      if (in_valid && mcnt != DEPTH)
        q.push_back('{in_pc, (in_waddr == 0) ? 4'h0 : in_be, in_waddr, in_wdata});
      mcnt = q.size();
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [3:0] be, input logic [4:0] wa, input logic [31:0] wd);
    in_valid = 1;
    in_pc = pc;
    in_be = be;
    in_waddr = wa;
    in_wdata = wd;
    tick();
    in_valid = 0;
  endtask

  initial begin
    #12 resetn = 1;
    tick();
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_we", rf_we, 0);
    check("rst_fwd_hit", fwd_hit, 0);
    tick(2);
    rf_ready = 1;
    push(32'h100, 4'hF, 5, 32'hDEADBEEF);
    #1;
    check("lat_we", rf_we, 4'hF);
    check("lat_waddr", rf_waddr, 5);
    check("lat_pc", debug_wb_pc, 32'h100);
    tick(2);
    rf_ready = 0;
    for (int i = 0; i < 5; i++) push(32'h1000 + 4 * i, 4'hF, 5'(i + 1), $urandom);
    check("full_ready", in_ready, 0);
    rf_ready = 1;
    tick(6);
    check("drained_commits", commits, 5);
    rf_ready = 0;
    fwd_raddr = 3;
    push(32'h200, 4'hF, 3, 32'h11);
    push(32'h204, 4'h3, 3, 32'h22);
    #1;
    check("fwd_young_hit", fwd_hit, 1);
    check("fwd_young_data", fwd_data, 32'h22);
    check("fwd_young_be", fwd_be, 4'h3);
    rf_ready = 1;
    tick(3);
    fwd_raddr = 0;
    push(32'h300, 4'hF, 0, 32'hFFFF);
    #1;
    check("r0_we", rf_we, 0);
    check("r0_pc", debug_wb_pc, 32'h300);
    tick(2);
    rf_ready = 0;
    push(32'h400, 4'hF, 7, $urandom);
    push(32'h404, 4'hF, 8, $urandom);
    rf_ready = 1;
    for (int i = 0; i < 20; i++) begin
      fwd_raddr = 5'($urandom_range(0, 9));
      push(32'h408 + 4 * i, 4'($urandom), 5'($urandom_range(0, 9)), $urandom);
      check("steady_ready", in_ready, 1);
    end
    tick(4);
    rf_ready = 0;
    fwd_raddr = 9;
    for (int i = 0; i < 3; i++) push(32'h500 + 4 * i, 4'hF, 9, 32'h90 + i);
    rf_ready = 1;
    #1 resetn = 0;
    #1;
    check("midrst_ready", in_ready, 1);
    check("midrst_we", rf_we, 0);
    check("midrst_pc", debug_wb_pc, 0);
    check("midrst_fwd", fwd_hit, 0);
    tick();
    resetn = 1;
    tick(3);
    check("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
